// File: rtl/adder_resp_checker.sv
// rtl/adder_resp_checker.sv - latency-matched response checker for a two-operand adder
module adder_resp_checker #(
    parameter int LAT = 1,
    parameter int IW  = 4,
    parameter int OW  = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          VLD,
    input  logic [IW-1:0] INPUT1,
    input  logic [IW-1:0] INPUT2,
    input  logic [OW-1:0] OUT,
    output logic [8:0]    CHK_CNT,
    output logic [8:0]    ERR_CNT,
    output logic          FAIL,
    output logic [IW-1:0] FIRST_IN1,
    output logic [IW-1:0] FIRST_IN2,
    output logic [OW-1:0] FIRST_OUT,
    output logic [OW-1:0] FIRST_EXP,
    output logic          COV_DONE,
    output logic [1:0]    STATE
);

    localparam int NPAIR = 1 << (2 * IW);
    localparam int D     = (LAT == 0) ? 1 : LAT;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FAILED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reference sum is formed once at the input side and travels with the pair.
    logic [IW:0]   sum_in;
    logic [OW-1:0] exp_in;
    assign sum_in = {1'b0, INPUT1} + {1'b0, INPUT2};
    assign exp_in = OW'(sum_in);

    logic          cmp_vld;
    logic [IW-1:0] cmp_in1;
    logic [IW-1:0] cmp_in2;
    logic [OW-1:0] cmp_exp;

    generate
        if (LAT == 0) begin : g_nodelay
            assign cmp_vld = VLD;
            assign cmp_in1 = INPUT1;
            assign cmp_in2 = INPUT2;
            assign cmp_exp = exp_in;
        end else begin : g_delay
            logic [D-1:0]  dv_q, dv_d;
            logic [IW-1:0] da_q [D];
            logic [IW-1:0] da_d [D];
            logic [IW-1:0] db_q [D];
            logic [IW-1:0] db_d [D];
            logic [OW-1:0] de_q [D];
            logic [OW-1:0] de_d [D];

            // Shift the operand pair and its reference sum one stage per cycle.
            always_comb begin
                dv_d    = dv_q;
                dv_d[0] = VLD;
                da_d[0] = INPUT1;
                db_d[0] = INPUT2;
                de_d[0] = exp_in;
                for (int i = 1; i < D; i++) begin
                    dv_d[i] = dv_q[i-1];
                    da_d[i] = da_q[i-1];
                    db_d[i] = db_q[i-1];
                    de_d[i] = de_q[i-1];
                end
                if (CLR) begin
                    dv_d = '0;
                end
            end

            // Only valid bits need reset; payload is qualified by them.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    dv_q <= '0;
                end else begin
                    dv_q <= dv_d;
                end
            end

            // Payload stages, no reset.
            always_ff @(posedge CLK) begin
                for (int i = 0; i < D; i++) begin
                    da_q[i] <= da_d[i];
                    db_q[i] <= db_d[i];
                    de_q[i] <= de_d[i];
                end
            end

            assign cmp_vld = dv_q[D-1];
            assign cmp_in1 = da_q[D-1];
            assign cmp_in2 = db_q[D-1];
            assign cmp_exp = de_q[D-1];
        end
    endgenerate

    logic [8:0]       chk_q, chk_d, err_q, err_d;
    logic             fail_q, fail_d, cov_done_q, cov_done_d;
    logic [IW-1:0]    fin1_q, fin1_d, fin2_q, fin2_d;
    logic [OW-1:0]    fout_q, fout_d, fexp_q, fexp_d;
    logic [NPAIR-1:0] cov_q, cov_d;
    state_t           state_q, state_d;
    logic             mism;
    logic [2*IW-1:0]  cov_idx;

    assign mism    = cmp_vld && (OUT != cmp_exp);
    assign cov_idx = {cmp_in1, cmp_in2};

    // Compare, count, capture first failure, track coverage and the checker FSM.
    always_comb begin
        chk_d      = chk_q;
        err_d      = err_q;
        fail_d     = fail_q;
        cov_done_d = cov_done_q;
        fin1_d     = fin1_q;
        fin2_d     = fin2_q;
        fout_d     = fout_q;
        fexp_d     = fexp_q;
        cov_d      = cov_q;
        state_d    = state_q;
        if (CLR) begin
            chk_d      = '0;
            err_d      = '0;
            fail_d     = 1'b0;
            cov_done_d = 1'b0;
            fin1_d     = '0;
            fin2_d     = '0;
            fout_d     = '0;
            fexp_d     = '0;
            cov_d      = '0;
            state_d    = S_IDLE;
        end else if (cmp_vld) begin
            if (!(&chk_q)) chk_d = chk_q + 9'd1;
            cov_d[cov_idx] = 1'b1;
            cov_done_d     = cov_done_q | (&cov_d);
            if (mism) begin
                if (!(&err_q)) err_d = err_q + 9'd1;
                fail_d = 1'b1;
                if (!fail_q) begin
                    fin1_d = cmp_in1;
                    fin2_d = cmp_in2;
                    fout_d = OUT;
                    fexp_d = cmp_exp;
                end
            end
            case (state_q)
                S_IDLE:   state_d = mism ? S_FAILED : S_RUN;
                S_RUN:    if (mism) state_d = S_FAILED;
                          else if ((&cov_d) && !fail_q) state_d = S_DONE;
                S_DONE:   if (mism) state_d = S_FAILED;
                default:  state_d = S_FAILED;
            endcase
        end
    end

    // Checker state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chk_q      <= '0;
            err_q      <= '0;
            fail_q     <= 1'b0;
            cov_done_q <= 1'b0;
            fin1_q     <= '0;
            fin2_q     <= '0;
            fout_q     <= '0;
            fexp_q     <= '0;
            cov_q      <= '0;
            state_q    <= S_IDLE;
        end else begin
            chk_q      <= chk_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            cov_done_q <= cov_done_d;
            fin1_q     <= fin1_d;
            fin2_q     <= fin2_d;
            fout_q     <= fout_d;
            fexp_q     <= fexp_d;
            cov_q      <= cov_d;
            state_q    <= state_d;
        end
    end

    assign CHK_CNT   = chk_q;
    assign ERR_CNT   = err_q;
    assign FAIL      = fail_q;
    assign FIRST_IN1 = fin1_q;
    assign FIRST_IN2 = fin2_q;
    assign FIRST_OUT = fout_q;
    assign FIRST_EXP = fexp_q;
    assign COV_DONE  = cov_done_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// tb/tb_adder_resp_checker.sv - randomized self-checking bench for adder_resp_checker
module tb_adder_resp_checker;

    logic       clk = 1'b0;
    logic       rst, clr, vld;
    logic [3:0] in1, in2;
    logic [5:0] out1, out3;

    logic [8:0] chk1, err1, chk3, err3;
    logic       fail1, fail3, cov1, cov3;
    logic [3:0] fa1, fb1, fa3, fb3;
    logic [5:0] fo1, fe1, fo3, fe3;
    logic [1:0] st1, st3;

    always #5 clk = ~clk;

    adder_resp_checker #(.LAT(1), .IW(4), .OW(6)) u_dut1 (
        .CLK(clk), .RST(rst), .CLR(clr), .VLD(vld), .INPUT1(in1), .INPUT2(in2), .OUT(out1),
        .CHK_CNT(chk1), .ERR_CNT(err1), .FAIL(fail1), .FIRST_IN1(fa1), .FIRST_IN2(fb1),
        .FIRST_OUT(fo1), .FIRST_EXP(fe1), .COV_DONE(cov1), .STATE(st1));

    adder_resp_checker #(.LAT(3), .IW(4), .OW(6)) u_dut3 (
        .CLK(clk), .RST(rst), .CLR(clr), .VLD(vld), .INPUT1(in1), .INPUT2(in2), .OUT(out3),
        .CHK_CNT(chk3), .ERR_CNT(err3), .FAIL(fail3), .FIRST_IN1(fa3), .FIRST_IN2(fb3),
        .FIRST_OUT(fo3), .FIRST_EXP(fe3), .COV_DONE(cov3), .STATE(st3));

    int checks = 0;
    int errors = 0;

    // operand history: index n = pair driven n cycles ago
    logic       hv [8];
    logic [3:0] ha [8];
    logic [3:0] hb [8];
    int mode1 = 0, mode3 = 0, lat3 = 3;

    // scoreboard per checker (0 = LAT1 instance, 1 = LAT3 instance)
    int         m_chk [2], m_err [2], m_covn [2], m_st [2];
    logic       m_fail [2];
    logic [3:0] m_fi1 [2], m_fi2 [2];
    logic [5:0] m_fo [2], m_fe [2];
    bit [255:0] m_cov [2];

    function automatic logic [5:0] adder(input logic [3:0] a, input logic [3:0] b, input int mode);
        logic [5:0] s;
        s = 6'(a) + 6'(b);
        if (mode == 1) s[4] = 1'b0;
        if (mode == 2) s = 6'd0;
        return s;
    endfunction

    function automatic logic [41:0] obs(input int k);
        if (k == 0) return {chk1, err1, fail1, fa1, fb1, fo1, fe1, cov1, st1};
        return {chk3, err3, fail3, fa3, fb3, fo3, fe3, cov3, st3};
    endfunction

    function automatic logic [41:0] model_vec(input int k);
        return {9'(m_chk[k]), 9'(m_err[k]), m_fail[k], m_fi1[k], m_fi2[k], m_fo[k], m_fe[k],
                m_covn[k] == 256, 2'(m_st[k])};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_chk[k] = 0; m_err[k] = 0; m_covn[k] = 0; m_st[k] = 0; m_fail[k] = 1'b0;
            m_fi1[k] = '0; m_fi2[k] = '0; m_fo[k] = '0; m_fe[k] = '0; m_cov[k] = '0;
        end
        for (int i = 0; i < 8; i++) hv[i] = 1'b0;
    endtask

    task automatic model_cmp(input int k, input logic [3:0] a, input logic [3:0] b, input logic [5:0] o);
        logic [5:0] e;
        e = 6'(a) + 6'(b);
        if (m_chk[k] < 511) m_chk[k]++;
        if (!m_cov[k][{a, b}]) begin
            m_cov[k][{a, b}] = 1'b1;
            m_covn[k]++;
        end
        if (o != e) begin
            if (m_err[k] < 511) m_err[k]++;
            if (!m_fail[k]) begin
                m_fi1[k] = a; m_fi2[k] = b; m_fo[k] = o; m_fe[k] = e;
            end
            m_fail[k] = 1'b1;
            m_st[k] = 2;
        end else if (m_st[k] == 0) begin
            m_st[k] = 1;
        end
        if (m_st[k] == 1 && m_covn[k] == 256) m_st[k] = 3;
    endtask

    // one clock of stimulus; the compare it schedules is registered on the next edge
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        @(posedge clk);
        #1;
        for (int i = 7; i > 0; i--) begin
            hv[i] = hv[i-1]; ha[i] = ha[i-1]; hb[i] = hb[i-1];
        end
        hv[0] = v; ha[0] = a; hb[0] = b;
        vld = v; in1 = a; in2 = b; clr = c;
        out1 = adder(ha[1], hb[1], mode1);
        out3 = adder(ha[lat3], hb[lat3], mode3);
        if (c) begin
            model_clear();
        end else begin
            if (hv[1]) model_cmp(0, ha[1], hb[1], out1);
            if (hv[3]) model_cmp(1, ha[3], hb[3], out3);
        end
    endtask

    task automatic flush();
        repeat (5) drive(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic sweep(input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = 8'(i);
            drive(1'b1, p[7:4], p[3:0], 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; vld = 1'b0; in1 = '0; in2 = '0; out1 = '0; out3 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 42'd0) begin
                errors++; $display("FAIL reset_state dut%0d: got %h want 0", k, obs(k));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        mode1 = 0; mode3 = 0; lat3 = 3;
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        sweep(256);
        flush();
        checks++;
        if ({chk1, err1, fail1, cov1, st1} !== {9'd256, 9'd0, 1'b0, 1'b1, 2'd3}) begin
            errors++; $display("FAIL exhaustive: got chk=%0d err=%0d fail=%b cov=%b st=%0d want 256 0 0 1 3",
                               chk1, err1, fail1, cov1, st1);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== model_vec(k)) begin
                errors++; $display("FAIL exhaustive_model dut%0d: got %h want %h", k, obs(k), model_vec(k));
            end
        end
    endtask

    task automatic test_fault();
        mode1 = 1;
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        sweep(256);
        flush();
        checks++;
        if ({fa1, fb1, fo1, fe1} !== {4'd1, 4'd15, 6'h00, 6'h10}) begin
            errors++; $display("FAIL fault_first: got in1=%0d in2=%0d out=%h exp=%h want 1 15 00 10",
                               fa1, fb1, fo1, fe1);
        end
        checks++;
        if ({err1, fail1, st1, cov1} !== {9'd120, 1'b1, 2'd2, 1'b1}) begin
            errors++; $display("FAIL fault_counts: got err=%0d fail=%b st=%0d cov=%b want 120 1 2 1",
                               err1, fail1, st1, cov1);
        end
        checks++;
        if (obs(0) !== model_vec(0)) begin
            errors++; $display("FAIL fault_model: got %h want %h", obs(0), model_vec(0));
        end
        mode1 = 0;
    endtask

    task automatic test_latency();
        logic [3:0] sa [40];
        logic [3:0] sb [40];
        for (int i = 0; i < 40; i++) begin
            sa[i] = 4'($urandom_range(0, 15));
            sb[i] = 4'($urandom_range(0, 15));
        end
        sa[0] = 4'd5; sb[0] = 4'd6;
        for (int pass = 0; pass < 2; pass++) begin
            lat3 = (pass == 0) ? 3 : 2;
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            for (int i = 0; i < 40; i++) begin
                drive(1'b1, sa[i], sb[i], 1'b0);
                drive(1'b0, 4'd0, 4'd0, 1'b0);
            end
            flush();
            checks++;
            if (pass == 0 && (err3 !== 9'd0 || chk3 !== 9'd40)) begin
                errors++; $display("FAIL latency_aligned: got err=%0d chk=%0d want 0 40", err3, chk3);
            end else if (pass == 1 && fail3 !== 1'b1) begin
                errors++; $display("FAIL latency_skew: got fail=%b want 1", fail3);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_vec(k)) begin
                    errors++; $display("FAIL latency_model pass%0d dut%0d: got %h want %h",
                                       pass, k, obs(k), model_vec(k));
                end
            end
        end
        lat3 = 3;
    endtask

    task automatic test_boundary();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        drive(1'b1, 4'd15, 4'd15, 1'b0);
        drive(1'b1, 4'd0, 4'd0, 1'b0);
        flush();
        checks++;
        if ({chk1, err1, fail1, st1} !== {9'd2, 9'd0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL boundary_sums: got chk=%0d err=%0d fail=%b st=%0d want 2 0 0 1",
                               chk1, err1, fail1, st1);
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        sweep(255);
        flush();
        checks++;
        if ({cov1, st1, cov3, st3} !== {1'b0, 2'd1, 1'b0, 2'd1}) begin
            errors++; $display("FAIL partial_sweep: got cov=%b st=%0d cov3=%b st3=%0d want 0 1 0 1",
                               cov1, st1, cov3, st3);
        end
        drive(1'b1, 4'd15, 4'd15, 1'b0);
        flush();
        checks++;
        if ({cov1, st1, chk1} !== {1'b1, 2'd3, 9'd256}) begin
            errors++; $display("FAIL last_pair: got cov=%b st=%0d chk=%0d want 1 3 256", cov1, st1, chk1);
        end
        checks++;
        if (obs(1) !== model_vec(1)) begin
            errors++; $display("FAIL boundary_model dut1: got %h want %h", obs(1), model_vec(1));
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (600) drive(1'b1, 4'd3, 4'd4, 1'b0);
        flush();
        checks++;
        if ({chk1, err1, cov1, st1} !== {9'd511, 9'd0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL chk_saturate: got chk=%0d err=%0d cov=%b st=%0d want 511 0 0 1",
                               chk1, err1, cov1, st1);
        end
        mode1 = 2;
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (600) drive(1'b1, 4'd3, 4'd4, 1'b0);
        flush();
        checks++;
        if ({err1, fa1, fb1, fo1, fe1} !== {9'd511, 4'd3, 4'd4, 6'd0, 6'd7}) begin
            errors++; $display("FAIL err_saturate: got err=%0d first=%0d,%0d,%h,%h want 511 3,4,00,07",
                               err1, fa1, fb1, fo1, fe1);
        end
        checks++;
        if (obs(0) !== model_vec(0)) begin
            errors++; $display("FAIL saturate_model: got %h want %h", obs(0), model_vec(0));
        end
        mode1 = 0;
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (5) drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        #2;
        rst = 1'b1;
        vld = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 42'd0) begin
                errors++; $display("FAIL reset_async dut%0d: got %h want 0", k, obs(k));
            end
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) drive(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if ({chk1, chk3, st1, st3} !== {9'd0, 9'd0, 2'd0, 2'd0}) begin
            errors++; $display("FAIL reset_inflight: got chk1=%0d chk3=%0d st1=%0d st3=%0d want 0 0 0 0",
                               chk1, chk3, st1, st3);
        end
    endtask

    task automatic test_clr_mismatch();
        mode1 = 2;
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        drive(1'b1, 4'd3, 4'd4, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        flush();
        checks++;
        if ({err1, fail1, st1, chk1} !== {9'd0, 1'b0, 2'd0, 9'd0}) begin
            errors++; $display("FAIL clr_priority: got err=%0d fail=%b st=%0d chk=%0d want 0 0 0 0",
                               err1, fail1, st1, chk1);
        end
        mode1 = 0;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            mode1 = ($urandom_range(0, 19) == 0) ? 1 : 0;
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        end
        mode1 = 0;
        flush();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== model_vec(k)) begin
                errors++; $display("FAIL random_stream dut%0d: got %h want %h", k, obs(k), model_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_fault();
        test_latency();
        test_boundary();
        test_saturation();
        test_reset_mid();
        test_clr_mismatch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
